// File: rtl/data_mem_pipe_pkg.sv
// Shared width encodings, byte-lane mask constants and access-legality helpers
// for the pipelined data memory.
package data_mem_pipe_pkg;

   // Access width / extension codes used across the load/store path.
   localparam logic [2:0] WIDTH_8S  = 3'b000;
   localparam logic [2:0] WIDTH_16S = 3'b001;
   localparam logic [2:0] WIDTH_32  = 3'b010;
   localparam logic [2:0] WIDTH_8U  = 3'b100;
   localparam logic [2:0] WIDTH_16U = 3'b101;

   // Byte-lane masks before shifting into position by addr[1:0].
   localparam logic [3:0] MASK_B = 4'b0001;
   localparam logic [3:0] MASK_H = 4'b0011;
   localparam logic [3:0] MASK_W = 4'b1111;

   // Control captured alongside the synchronous array read.
   typedef struct packed {
      logic       we;
      logic       fault;
      logic [1:0] lsb;
      logic [2:0] width;
   } stage_ctl_t;

   function automatic logic width_legal(input logic [2:0] w);
      return (w == WIDTH_8S) || (w == WIDTH_8U) || (w == WIDTH_16S) ||
             (w == WIDTH_16U) || (w == WIDTH_32);
   endfunction

   function automatic logic width_aligned(input logic [2:0] w, input logic [1:0] lsb);
      case (w)
         WIDTH_16S, WIDTH_16U: width_aligned = !lsb[0];
         WIDTH_32:             width_aligned = (lsb == 2'b00);
         default:              width_aligned = 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] width_mask(input logic [2:0] w, input logic [1:0] lsb);
      case (w)
         WIDTH_8S, WIDTH_8U:   width_mask = MASK_B << lsb;
         WIDTH_16S, WIDTH_16U: width_mask = MASK_H << lsb;
         WIDTH_32:             width_mask = MASK_W;
         default:              width_mask = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/data_mem_pipe_load_align_ext.sv
// Load lane select and sign/zero extension; purely combinational.
module load_align_ext
   import data_mem_pipe_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lsb,
   input  logic [2:0]  width_src,
   output logic [31:0] data
);

   logic [31:0] sh;

   // Shift the addressed lane down to bit 0, then extend per width code.
   always_comb begin
      sh   = word >> {lsb, 3'b000};
      data = 32'h0;
      case (width_src)
         WIDTH_8S:  data = {{24{sh[7]}}, sh[7:0]};
         WIDTH_8U:  data = {24'h0, sh[7:0]};
         WIDTH_16S: data = {{16{sh[15]}}, sh[15:0]};
         WIDTH_16U: data = {16'h0, sh[15:0]};
         WIDTH_32:  data = word;
         default:   data = 32'h0;
      endcase
   end

endmodule

// File: rtl/data_mem_pipe.sv
// Pipelined byte-write data memory: valid/ready request, in-order response after
// RSP_LATENCY (1 or 2) cycles, faults for misaligned/out-of-range/illegal widths.
module data_mem_pipe
   import data_mem_pipe_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int ADDR_WIDTH  = 32,
   parameter int RSP_LATENCY = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [2:0]            req_width_src_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [31:0]           req_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [31:0]           rsp_rdata_o,
   output logic                  rsp_fault_o
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   logic [31:0]          mem [DEPTH_WORDS];
   logic [31:0]          rd_word;
   logic [31:0]          wrep;
   logic [31:0]          ext_data;
   logic [31:0]          s1_rdata;
   logic                 s1_fault;
   logic [3:0]           mask;
   logic [IDX_W-1:0]     idx;
   logic                 stall;
   logic                 accept;
   logic                 fault_in;
   logic [RSP_LATENCY:1] vld_pipe;
   stage_ctl_t           s1_ctl;

   // A held response freezes every stage, including the array read/write.
   assign stall       = rsp_valid_o && !rsp_ready_i;
   assign req_ready_o = !stall;
   assign accept      = req_valid_i && !stall;
   assign idx         = req_addr_i[IDX_W+1:2];
   assign mask        = width_mask(req_width_src_i, req_addr_i[1:0]);
   assign fault_in    = !width_legal(req_width_src_i) ||
                        !width_aligned(req_width_src_i, req_addr_i[1:0]) ||
                        (req_addr_i[ADDR_WIDTH-1:IDX_W+2] != '0);
   assign rsp_valid_o = vld_pipe[RSP_LATENCY];

   // Replicate right-aligned store data so every lane the mask can pick has it.
   always_comb begin
      wrep = req_wdata_i;
      case (req_width_src_i)
         WIDTH_8S, WIDTH_8U:   wrep = {4{req_wdata_i[7:0]}};
         WIDTH_16S, WIDTH_16U: wrep = {2{req_wdata_i[15:0]}};
         default:              wrep = req_wdata_i;
      endcase
   end

   // Byte-lane write; faulted stores (including aliasing out-of-range ones) never write.
   always_ff @(posedge clk_i) begin
      if (accept && req_we_i && !fault_in) begin
         for (int l = 0; l < 4; l++)
            if (mask[l]) mem[idx][8*l +: 8] <= wrep[8*l +: 8];
      end
   end

   // Synchronous array read, enabled only on acceptance so it holds under stall.
   always_ff @(posedge clk_i) begin
      if (accept) rd_word <= mem[idx];
   end

   // Valid shift register and per-request control, dropped on reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         vld_pipe <= '0;
         s1_ctl   <= '0;
      end else if (!stall) begin
         vld_pipe <= RSP_LATENCY'({vld_pipe, accept});
         s1_ctl   <= '{we: req_we_i, fault: fault_in, lsb: req_addr_i[1:0],
                       width: req_width_src_i};
      end
   end

   load_align_ext u_ext (
      .word      (rd_word),
      .lsb       (s1_ctl.lsb),
      .width_src (s1_ctl.width),
      .data      (ext_data)
   );

   // Stores and faults return zero data; the gate also hides the unreset array.
   assign s1_rdata = (vld_pipe[1] && !s1_ctl.we && !s1_ctl.fault) ? ext_data : 32'h0;
   assign s1_fault = vld_pipe[1] && s1_ctl.fault;

   if (RSP_LATENCY == 1) begin : g_lat1
      assign rsp_rdata_o = s1_rdata;
      assign rsp_fault_o = s1_fault;
   end else begin : g_lat2
      logic [31:0] s2_rdata;
      logic        s2_fault;

      // Extra output register after extension for the two-cycle variant.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
         if (!rst_n_i) begin
            s2_rdata <= 32'h0;
            s2_fault <= 1'b0;
         end else if (!stall) begin
            s2_rdata <= s1_rdata;
            s2_fault <= s1_fault;
         end
      end

      assign rsp_rdata_o = s2_rdata;
      assign rsp_fault_o = s2_fault;
   end

endmodule

// File: doc/data_mem_pipe.md
# data_mem_pipe

Parametrised, pipelined successor to the single-cycle data memory on the CPU load/store path. Accepts one request per cycle over a valid/ready handshake and performs byte/halfword/word stores through byte-lane write masks. Returns loads with sign or zero extension after a configurable registered latency, and reports misaligned, out-of-range and illegal-width accesses as faults instead of silently corrupting memory. Sits between the MEM stage and the backing array. Response backpressure stalls the whole block.

## Interface
- `DEPTH_WORDS`, 64: number of 32-bit words; power of two, ≥4.
- `ADDR_WIDTH`, 32: byte-address width.
- `RSP_LATENCY`, 1: cycles from acceptance to response; legal values 1 or 2.

Ports:
- `clk_i`, in, 1: clock; all state updates on the rising edge.
- `rst_n_i`, in, 1: reset; asynchronous, active-low.
- `req_valid_i`, in, 1: request present.
- `req_ready_o`, out, 1: block can accept a request this cycle.
- `req_we_i`, in, 1: 1 = store, 0 = load.
- `req_width_src_i`, in, 3: access width and extension; uses the shared `WIDTH_*` encodings.
- `req_addr_i`, in, ADDR_WIDTH: byte address.
- `req_wdata_i`, in, 32: store data, right-aligned (lane 0 holds the byte or halfword).
- `rsp_valid_o`, out, 1: response present.
- `rsp_ready_i`, in, 1: consumer takes the response.
- `rsp_rdata_o`, out, 32: load data after alignment and extension; 0 for stores and faults.
- `rsp_fault_o`, out, 1: access faulted.

## Operation
- Acceptance: `req_valid_i && req_ready_o` at a rising edge.
- Every accepted request yields exactly one response, in order.
- `req_ready_o = !(rsp_valid_o && !rsp_ready_i)`.
  - Stall is global: the pipeline registers and the array read enable hold.
- Width handling:
  - `WIDTH_32` uses mask 4'b1111; requires `addr[1:0]==0`.
  - `WIDTH_16S` and `WIDTH_16U` use mask 4'b0011 << `addr[1:0]`; require `addr[0]==0`.
  - `WIDTH_8S` and `WIDTH_8U` use mask 4'b0001 << `addr[1:0]`.
- Store: on acceptance, write the lanes selected by the mask with `wdata` replicated into position. Other lanes are unchanged. The response is `rdata=0, fault=0`.
- Load: read the word at `addr[log2(DEPTH_WORDS)+1:2]`, select the lane by `addr[1:0]`, then sign-extend (`*S`) or zero-extend (`*U`).
- Fault conditions, any of:
  - misaligned address;
  - `addr >= DEPTH_WORDS*4`;
  - `width_src` not one of the five legal codes.
- A faulted store does not write. A faulted load or store responds with `rdata=0, fault=1`.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data. The write and read occur on distinct acceptance edges, so no forwarding is needed.
- The array is not reset; contents are undefined until written.

## Timing
- Reset (async assert, sync-to-clock deassert is upstream's job):
  - `rsp_valid_o=0`, `rsp_rdata_o=0`, `rsp_fault_o=0`, all internal valid bits 0.
  - `req_ready_o` is therefore 1.
- `RSP_LATENCY=1`: a request accepted at edge t gives `rsp_valid_o=1` from edge t onward. The array read is synchronous and extension is combinational into the output register.
- `RSP_LATENCY=2`: one extra register stage after extension; the response appears after edge t+1.
- Throughput is one request per cycle with `rsp_ready_i` held high.
- Stall: while `rsp_valid_o && !rsp_ready_i`, every output and stage holds. A request presented during a stall is not accepted and has no side effect, including no write.
- Simultaneous response consume and new request is allowed; the next response appears on schedule.
- Reset mid-operation drops in-flight responses. Stores accepted before reset remain in the array.

## Structure
- Shared package:
  - the `WIDTH_*` constants (existing encodings);
  - a `width_legal()` function;
  - the mask-generation constants.
- Sub-module `load_align_ext`: combinational lane select and sign/zero extension, taking the 32-bit word, `addr[1:0]` and `width_src`, and producing 32-bit data.
- The array is a plain `logic [31:0] mem [DEPTH_WORDS]` with per-lane write enable, inferrable as byte-write BRAM.

## Test plan
- Word sweep: store `i` to addresses `4*i`, i=0..63, then load each back as `WIDTH_32`; expect `rdata=i`, `fault=0`, responses in order at one per cycle.
- Sub-word store then extend:
  - store 0xFF as `WIDTH_8S` to address 5;
  - load address 5 as `WIDTH_8S` and expect 0xFFFFFFFF; as `WIDTH_8U`, expect 0x000000FF;
  - load word 4 and expect only bits [15:8] changed.
- Halfword lane:
  - store 0x8001 as `WIDTH_16S` to address 0x12;
  - `WIDTH_16S` load returns 0xFFFF8001; `WIDTH_16U` returns 0x00008001.
- Faults, each expecting `fault=1, rdata=0`, with the following word load showing it unchanged:
  - `WIDTH_32` store to address 0x2;
  - `WIDTH_16U` load from address 0x3;
  - load from address 256 with `DEPTH_WORDS=64`;
  - width code 3'b111.
- Backpressure: hold `rsp_ready_i=0` for 3 cycles with `req_valid_i=1`:
  - `req_ready_o=0` and the response holds;
  - the blocked store does not write until accepted;
  - repeat with `RSP_LATENCY=2`.
- Reset mid-stream:
  - assert `rst_n_i` with 2 responses in flight; expect outputs 0 immediately and no stale response after release;
  - earlier stores still read back.
